signed_alu_seq: RTL and testbench

Sequential signed arithmetic core of the signed calculator. It sits directly downstream of the 4-bit-to-6-bit two's-complement conversion stage and accepts one operand pair plus an opcode per transaction over a valid/ready handshake. It computes add, subtract or multiply (iterative shift-add), and returns a 12-bit two's-complement result. The same result is also given in sign-magnitude form for the display stage.

---
 rtl/signed_calc_pkg.sv | 23 ++
 rtl/signed_alu_seq_if.sv | 31 +++
 rtl/seq_mult_u.sv | 57 +++++
 rtl/signed_alu_seq.sv | 161 ++++++++++++++++
 tb/tb_signed_alu_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/signed_calc_pkg.sv
// Shared definitions for the signed calculator datapath: opcodes, core states
// and default operand/result widths.
package signed_calc_pkg;

    localparam int W_IN      = 6;
    localparam int W_OUT     = 2 * W_IN;
    localparam int MUL_STEPS = W_IN;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDSUB,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/signed_alu_seq_if.sv
// Operand/opcode request and result response channels of the signed ALU core.
interface signed_alu_seq_if #(
    parameter int W_IN = signed_calc_pkg::W_IN
);
    localparam int W_OUT = 2 * W_IN;

    logic [W_IN-1:0]  a;
    logic [W_IN-1:0]  b;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [W_OUT-1:0] res;
    logic             res_sign;
    logic [W_OUT-2:0] res_mag;
    logic             ovf;
    logic             err;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, res, res_sign, res_mag, ovf, err, out_valid, busy
    );

    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, res, res_sign, res_mag, ovf, err, out_valid, busy
    );

endinterface

// File: rtl/seq_mult_u.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// W_IN steps after start. done/product are valid during the final step cycle.
module seq_mult_u #(
    parameter int W_IN = signed_calc_pkg::MUL_STEPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_IN-1:0]   a_mag,
    input  logic [W_IN-1:0]   b_mag,
    output logic              done,
    output logic [2*W_IN-1:0] product
);

    localparam int W_OUT = 2 * W_IN;
    localparam int CNT_W = $clog2(W_IN + 1);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [W_OUT-1:0] mcand;
    logic [W_OUT-1:0] acc;
    logic [W_OUT-1:0] acc_sum;
    logic [W_IN-1:0]  mplier;

    // The sum including the current step is exposed so the caller can latch the
    // finished product on the same edge that performs the last step.
    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign done    = running && (cnt == CNT_W'(W_IN - 1));
    assign product = acc_sum;

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            mcand   <= {{W_IN{1'b0}}, a_mag};
            mplier  <= b_mag;
            acc     <= '0;
        end else if (running) begin
            acc     <= acc_sum;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/signed_alu_seq.sv
// Sequential signed add/sub/multiply core with valid/ready handshakes and a
// registered sign-magnitude view of the result for the display stage.
module signed_alu_seq #(
    parameter int W_IN = signed_calc_pkg::W_IN
) (
    input  logic           clk,
    input  logic           rst,
    signed_alu_seq_if.slave bus
);

    import signed_calc_pkg::*;

    localparam int W_OUT = 2 * W_IN;
    localparam int LO_INT = -(2 ** (W_IN - 1));
    localparam int HI_INT = (2 ** (W_IN - 1)) - 1;
    localparam logic signed [W_OUT-1:0] LIM_LO = W_OUT'(LO_INT);
    localparam logic signed [W_OUT-1:0] LIM_HI = W_OUT'(HI_INT);

    state_t state, state_next;

    op_t              op_q;
    logic [W_IN-1:0]  a_q;
    logic [W_IN-1:0]  b_q;
    logic             sign_q;

    logic [W_OUT-1:0] res_q;
    logic             res_sign_q;
    logic [W_OUT-2:0] res_mag_q;
    logic             ovf_q;
    logic             err_q;

    logic             accept;
    op_t              op_in;
    logic             mul_start;
    logic             mul_done;
    logic [W_OUT-1:0] mul_prod;
    logic [W_IN-1:0]  a_mag;
    logic [W_IN-1:0]  b_mag;

    logic                    load_res;
    logic                    err_new;
    logic signed [W_OUT-1:0] res_new;
    logic signed [W_OUT-1:0] a_ext;
    logic signed [W_OUT-1:0] b_ext;
    logic [W_OUT-1:0]        res_abs;

    assign op_in     = op_t'(bus.op);
    assign accept    = bus.in_valid && (state == IDLE);
    assign mul_start = accept && (op_in == OP_MUL);

    // Magnitudes are taken from the live inputs on the accept edge; -(-2^(W_IN-1))
    // wraps to the same bit pattern, which reads correctly as unsigned.
    assign a_mag = bus.a[W_IN-1] ? -bus.a : bus.a;
    assign b_mag = bus.b[W_IN-1] ? -bus.b : bus.b;

    assign a_ext   = {{W_IN{a_q[W_IN-1]}}, a_q};
    assign b_ext   = {{W_IN{b_q[W_IN-1]}}, b_q};
    assign res_abs = res_new[W_OUT-1] ? -res_new : res_new;

    seq_mult_u #(.W_IN(W_IN)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        load_res   = 1'b0;
        err_new    = 1'b0;
        res_new    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_ADD, OP_SUB: state_next = ADDSUB;
                        OP_MUL:         state_next = MUL;
                        default: begin
                            state_next = DONE;
                            load_res   = 1'b1;
                            err_new    = 1'b1;
                        end
                    endcase
                end
            end
            ADDSUB: begin
                state_next = DONE;
                load_res   = 1'b1;
                res_new    = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
            end
            MUL: begin
                if (mul_done) begin
                    state_next = DONE;
                    load_res   = 1'b1;
                    res_new    = sign_q ? -mul_prod : mul_prod;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result fields are written only when a new result lands, so they hold
    // steady through backpressure and after the output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            sign_q     <= 1'b0;
            res_q      <= '0;
            res_sign_q <= 1'b0;
            res_mag_q  <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= bus.a;
                b_q    <= bus.b;
                op_q   <= op_in;
                sign_q <= bus.a[W_IN-1] ^ bus.b[W_IN-1];
                if (op_in != OP_RSV) begin
                    err_q <= 1'b0;
                end
            end
            if (load_res) begin
                res_q      <= res_new;
                res_sign_q <= res_new[W_OUT-1];
                res_mag_q  <= res_abs[W_OUT-2:0];
                ovf_q      <= (res_new < LIM_LO) || (res_new > LIM_HI);
                err_q      <= err_new;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.res       = res_q;
    assign bus.res_sign  = res_sign_q;
    assign bus.res_mag   = res_mag_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_signed_alu_seq.sv
// Self-checking bench for signed_alu_seq: directed vector table, reset abort
// sequence and randomized transactions against an integer reference model.
module tb_signed_alu_seq;

    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic [1:0]  op;
        logic [11:0] res;
        bit          sign;
        logic [10:0] mag;
        bit          ovf;
        bit          err;
        int          lat;
        int          bp;
        bit          toggle;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    signed_alu_seq_if #(.W_IN(6)) bus ();

    signed_alu_seq #(.W_IN(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the signed operand values.
    function automatic vec_t model(input logic [5:0] ma, input logic [5:0] mb, input logic [1:0] mop);
        vec_t v;
        int   sa;
        int   sb;
        int   x;
        int   ax;
        sa = $signed(ma);
        sb = $signed(mb);
        case (mop)
            2'd0:    begin x = sa + sb; v.lat = 1; end
            2'd1:    begin x = sa - sb; v.lat = 1; end
            2'd2:    begin x = sa * sb; v.lat = 6; end
            default: begin x = 0;       v.lat = 0; end
        endcase
        ax       = (x < 0) ? -x : x;
        v.a      = ma;
        v.b      = mb;
        v.op     = mop;
        v.res    = x[11:0];
        v.sign   = (x < 0);
        v.mag    = ax[10:0];
        v.ovf    = (x > 31) || (x < -32);
        v.err    = (mop == 2'd3);
        v.bp     = 0;
        v.toggle = 1'b0;
        return v;
    endfunction

    task automatic scramble_inputs(input bit with_valid);
        bus.a  = 6'($urandom);
        bus.b  = 6'($urandom);
        bus.op = 2'($urandom);
        if (with_valid) bus.in_valid = 1'($urandom);
    endtask

    // Issues one transaction at #1 after an edge and follows it to the handshake.
    task automatic run_txn(input vec_t v, input string tag);
        int n;
        check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.a        = v.a;
        bus.b        = v.b;
        bus.op       = v.op;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        scramble_inputs(1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            if (v.toggle) begin
                check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
                scramble_inputs(1'b1);
            end
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(v.lat));
        check({tag, "_res"}, 32'(bus.res), 32'(v.res));
        check({tag, "_sign"}, 32'(bus.res_sign), 32'(v.sign));
        check({tag, "_mag"}, 32'(bus.res_mag), 32'(v.mag));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(v.ovf));
        check({tag, "_err"}, 32'(bus.err), 32'(v.err));
        for (int i = 0; i < v.bp; i++) begin
            if (v.toggle) scramble_inputs(1'b1);
            @(posedge clk); #1;
            check({tag, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_bp_in_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_bp_res"}, 32'(bus.res), 32'(v.res));
            check({tag, "_bp_mag"}, 32'(bus.res_mag), 32'(v.mag));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_post_res_held"}, 32'(bus.res), 32'(v.res));
    endtask

    vec_t vecs[6];

    initial begin
        vec_t rv;
        int   seen;
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        //             a      b      op     res      s  mag      o  e  lat bp tog
        vecs[0] = '{6'h3B, 6'h07, 2'b00, 12'h002, 0, 11'd2,    0, 0, 1,  0, 0};
        vecs[1] = '{6'h20, 6'h1F, 2'b01, 12'hFC1, 1, 11'd63,   1, 0, 1,  0, 0};
        vecs[2] = '{6'h20, 6'h20, 2'b10, 12'h400, 0, 11'd1024, 1, 0, 6,  0, 0};
        vecs[3] = '{6'h3D, 6'h05, 2'b10, 12'hFF1, 1, 11'd15,   0, 0, 6,  4, 1};
        vecs[4] = '{6'h2A, 6'h11, 2'b11, 12'h000, 0, 11'd0,    0, 1, 0,  0, 0};
        vecs[5] = '{6'h01, 6'h01, 2'b00, 12'h002, 0, 11'd2,    0, 0, 1,  0, 0};

        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_res", 32'(bus.res), 32'd0);
        check("rst_flags", {29'd0, bus.res_sign, bus.ovf, bus.err}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort a multiply after its third step; nothing may come out of it.
        bus.a        = 6'h20;
        bus.b        = 6'h20;
        bus.op       = 2'b10;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_res", 32'(bus.res), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        bus.out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) seen++;
        end
        bus.out_ready = 1'b0;
        check("abort_no_result", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rv        = model(6'($urandom), 6'($urandom), 2'($urandom));
            rv.bp     = int'($urandom_range(0, 2));
            rv.toggle = 1'($urandom);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
